// File: rtl/hydra_rd_port_sink.sv
// hydra_rd_port_sink
//   Read-side endpoint for one hydra output port. It pulses ready to request a packet,
//   then receives rd_sop / header / payload / rd_eop. It checks the header fields, the
//   payload sequence and the length, and keeps packet and error counts plus sticky flags.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   enable         allows new ready requests; a packet already in flight is never aborted
//   ready          one-cycle request pulse
//   rd_sop/rd_eop  start / end of packet pulses
//   rd_vld/rd_data data valid and 16-bit word (header first, then payload)
//   busy           high from the ready pulse until packet end or timeout
//   pkt_done       one-cycle pulse per packet completed in DATA
//   pkt_cnt        completed packets, wraps
//   err_cnt        erroneous packets/events, saturates
//   err_flags      sticky {TMO,PROTO,SEQ,DEST,LEN,HDR}
//   last_len/prio  fields of the last header taken
module hydra_rd_port_sink #(
   parameter logic [3:0]  PORT_ID   = 4'd0,
   parameter int unsigned GAP       = 30,
   parameter int unsigned TIMEOUT   = 1024,
   parameter bit          CHECK_SEQ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        ready,
   input  logic        rd_sop,
   input  logic        rd_eop,
   input  logic        rd_vld,
   input  logic [15:0] rd_data,
   output logic        busy,
   output logic        pkt_done,
   output logic [15:0] pkt_cnt,
   output logic [15:0] err_cnt,
   output logic [5:0]  err_flags,
   output logic [8:0]  last_len,
   output logic [2:0]  last_prio
);

   localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
   // Timeout counter only ever needs to hold TIMEOUT-1.
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [GW-1:0] GAP_L    = GW'(GAP);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam int F_HDR   = 0;
   localparam int F_LEN   = 1;
   localparam int F_DEST  = 2;
   localparam int F_SEQ   = 3;
   localparam int F_PROTO = 4;
   localparam int F_TMO   = 5;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HDR, S_DATA} state_t;

   state_t         state;
   logic [GW-1:0]  gap_cnt;
   logic [TW-1:0]  tmo_cnt;
   logic [8:0]     word_cnt;
   logic           pkt_err;     // any per-packet error seen since the header

   logic           proto_ev, tmo_ev, eop_err, seq_bad, len_bad, dest_bad, len_zero;
   logic [8:0]     word_nxt;
   logic [1:0]     err_inc;
   logic [16:0]    err_sum;

   always_comb begin
      proto_ev = 1'b0;
      tmo_ev   = 1'b0;
      eop_err  = 1'b0;
      word_nxt = word_cnt;
      if (rd_vld && word_cnt != 9'h1FF)
         word_nxt = word_cnt + 9'd1;
      // Sequence check uses the count before this word; the word itself is counted first,
      // so the length compare at eop sees the updated count.
      seq_bad  = CHECK_SEQ && rd_vld && (rd_data != ({7'd0, word_cnt} + 16'd1));
      len_bad  = (word_nxt != last_len);
      dest_bad = (rd_data[3:0] != PORT_ID);
      len_zero = (rd_data[15:7] == 9'd0);
      unique case (state)
         S_IDLE, S_REQ: proto_ev = rd_sop | rd_eop | rd_vld;
         S_WAIT: begin
            proto_ev = rd_vld | rd_eop;
            tmo_ev   = !rd_sop && (tmo_cnt == TMO_LAST);
         end
         S_HDR:  proto_ev = rd_sop | rd_eop;
         S_DATA: begin
            proto_ev = rd_sop;
            eop_err  = !rd_sop && rd_eop && (pkt_err | seq_bad | len_bad);
         end
         default: ;
      endcase
      // A timeout and a stray beat can land in the same cycle, hence up to +2.
      err_inc = {1'b0, proto_ev} + {1'b0, tmo_ev} + {1'b0, eop_err};
      err_sum = {1'b0, err_cnt} + {15'd0, err_inc};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         gap_cnt   <= GAP_L;
         tmo_cnt   <= '0;
         word_cnt  <= '0;
         pkt_err   <= 1'b0;
         ready     <= 1'b0;
         busy      <= 1'b0;
         pkt_done  <= 1'b0;
         pkt_cnt   <= '0;
         err_cnt   <= '0;
         err_flags <= '0;
         last_len  <= '0;
         last_prio <= '0;
      end else begin
         ready    <= 1'b0;
         pkt_done <= 1'b0;
         err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         if (proto_ev)
            err_flags[F_PROTO] <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (gap_cnt != '0)
                  gap_cnt <= gap_cnt - GW'(1);
               else if (enable) begin
                  state <= S_REQ;
                  ready <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            S_REQ: begin
               state   <= S_WAIT;
               tmo_cnt <= '0;
            end
            S_WAIT: begin
               // A word arriving with sop is not the header; the header is the next vld.
               if (rd_sop)
                  state <= S_HDR;
               else if (tmo_ev) begin
                  err_flags[F_TMO] <= 1'b1;
                  state   <= S_IDLE;
                  gap_cnt <= GAP_L;
                  busy    <= 1'b0;
               end else
                  tmo_cnt <= tmo_cnt + TW'(1);
            end
            S_HDR: begin
               if (rd_sop) begin
                  state <= S_HDR;            // restart: wait for a fresh header
               end else if (rd_eop) begin
                  state   <= S_IDLE;         // aborted packet, not counted
                  gap_cnt <= GAP_L;
                  busy    <= 1'b0;
               end else if (rd_vld) begin
                  last_len  <= rd_data[15:7];
                  last_prio <= rd_data[6:4];
                  word_cnt  <= '0;
                  pkt_err   <= len_zero | dest_bad;
                  if (len_zero) err_flags[F_HDR]  <= 1'b1;
                  if (dest_bad) err_flags[F_DEST] <= 1'b1;
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               if (rd_sop) begin
                  state <= S_HDR;            // old packet dropped uncounted
               end else begin
                  word_cnt <= word_nxt;
                  if (seq_bad) err_flags[F_SEQ] <= 1'b1;
                  pkt_err <= pkt_err | seq_bad;
                  if (rd_eop) begin
                     if (len_bad) err_flags[F_LEN] <= 1'b1;
                     pkt_done <= 1'b1;
                     pkt_cnt  <= pkt_cnt + 16'd1;
                     state    <= S_IDLE;
                     gap_cnt  <= GAP_L;
                     busy     <= 1'b0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hydra_rd_port_sink.sv
// Directed bench for hydra_rd_port_sink: each completed packet pushes its expected
// counters/flags/header fields to a scoreboard that a monitor pops on pkt_done.
module tb_hydra_rd_port_sink;

   localparam logic [3:0] PID   = 4'd5;
   localparam int         GAP_P = 30;
   localparam int         TMO_P = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        rd_sop = 1'b0, rd_eop = 1'b0, rd_vld = 1'b0;
   logic [15:0] rd_data = '0;
   logic        ready, busy, pkt_done;
   logic [15:0] pkt_cnt, err_cnt;
   logic [5:0]  err_flags;
   logic [8:0]  last_len;
   logic [2:0]  last_prio;

   hydra_rd_port_sink #(.PORT_ID(PID), .GAP(GAP_P), .TIMEOUT(TMO_P), .CHECK_SEQ(1'b1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .ready(ready),
      .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
      .busy(busy), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
      .err_flags(err_flags), .last_len(last_len), .last_prio(last_prio)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         pkt;
      int         err;
      logic [5:0] flags;
      logic [8:0] len;
      logic [2:0] prio;
   } exp_t;
   exp_t sb[$];

   int         m_pkt, m_err;
   logic [5:0] m_flags;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (pkt_done === 1'b1) begin
         chk("sb_depth", 32'(sb.size()), 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("done_pkt_cnt",   32'(pkt_cnt),   32'(e.pkt));
            chk("done_err_cnt",   32'(err_cnt),   32'(e.err));
            chk("done_err_flags", 32'(err_flags), 32'(e.flags));
            chk("done_last_len",  32'(last_len),  32'(e.len));
            chk("done_last_prio", 32'(last_prio), 32'(e.prio));
         end
      end
   end

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ready !== 1'b1 && n < 3000);
      if (ready !== 1'b1) chk("ready_wait", 32'(ready), 32'd1);
   endtask

   // sop, header, nw payload words (k, or 0 at bad_idx); eop on last word when fin.
   task automatic drive_body(input logic [15:0] hdr, input int nw, input int bad_idx, input bit fin);
      exp_t e;
      logic [5:0] f;
      if (fin) begin
         f = '0;
         if (hdr[15:7] == 9'd0)       f[0] = 1'b1;
         if (nw != int'(hdr[15:7]))   f[1] = 1'b1;
         if (hdr[3:0] != PID)         f[2] = 1'b1;
         if (bad_idx >= 1 && bad_idx <= nw) f[3] = 1'b1;
         m_flags |= f;
         if (f != '0) m_err++;
         m_pkt++;
         e.pkt = m_pkt; e.err = m_err; e.flags = m_flags;
         e.len = hdr[15:7]; e.prio = hdr[6:4];
         sb.push_back(e);
      end
      @(negedge clk); rd_sop = 1'b1; rd_vld = 1'b0; rd_eop = 1'b0; rd_data = '0;
      @(negedge clk); rd_sop = 1'b0; rd_vld = 1'b1; rd_data = hdr;
      for (int k = 1; k <= nw; k++) begin
         @(negedge clk);
         rd_vld  = 1'b1;
         rd_data = (k == bad_idx) ? 16'h0000 : 16'(k);
         rd_eop  = fin && (k == nw);
      end
      if (fin) begin
         if (nw == 0) begin
            @(negedge clk); rd_vld = 1'b0; rd_eop = 1'b1; rd_data = '0;
         end
         @(negedge clk); rd_vld = 1'b0; rd_eop = 1'b0; rd_data = '0;
      end
   endtask

   task automatic do_reset();
      int n;
      rst = 1'b1; enable = 1'b1;
      rd_sop = 1'b0; rd_eop = 1'b0; rd_vld = 1'b0; rd_data = '0;
      m_pkt = 0; m_err = 0; m_flags = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready",     32'(ready),     32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_pkt_cnt",   32'(pkt_cnt),   32'd0);
      chk("rst_err_cnt",   32'(err_cnt),   32'd0);
      chk("rst_err_flags", 32'(err_flags), 32'd0);
      chk("rst_last_len",  32'(last_len),  32'd0);
      rst = 1'b0;
      wait_ready(n);
      chk("ready_after_rst", 32'(n), 32'(GAP_P + 1));
      chk("busy_with_ready", 32'(busy), 32'd1);
   endtask

   initial begin
      int n, c;
      logic [8:0] l;
      logic [15:0] hdr;

      // reset timing, then a clean packet of 31 words
      do_reset();
      @(negedge clk);
      chk("ready_pulse_low", 32'(ready), 32'd0);
      chk("busy_held",       32'(busy),  32'd1);
      drive_body(16'h0F80 | {12'd0, PID}, 31, 0, 1'b1);
      @(negedge clk);
      chk("t2_busy_low",   32'(busy),      32'd0);
      chk("t2_err_flags",  32'(err_flags), 32'd0);

      // short payload -> length error
      do_reset();
      drive_body(16'h0F80 | {12'd0, PID}, 30, 0, 1'b1);
      @(negedge clk);
      chk("t3_err_cnt", 32'(err_cnt),   32'd1);
      chk("t3_flags",   32'(err_flags), 32'h02);

      // wrong dest plus a bad payload word: two flags, one count
      do_reset();
      drive_body(16'h0F80 | {12'd0, PID + 4'd1}, 31, 5, 1'b1);
      @(negedge clk);
      chk("t4_err_cnt", 32'(err_cnt),   32'd1);
      chk("t4_flags",   32'(err_flags), 32'h0C);

      // no sop -> timeout, then the next ready after the gap
      do_reset();
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (busy === 1'b1 && c < 3000);
      chk("t5_busy_drop", 32'(c),         32'(TMO_P + 1));
      chk("t5_flags",     32'(err_flags), 32'h20);
      chk("t5_err_cnt",   32'(err_cnt),   32'd1);
      chk("t5_pkt_cnt",   32'(pkt_cnt),   32'd0);
      wait_ready(n);
      chk("t5_ready_gap", 32'(n), 32'(GAP_P + 1));

      // sop mid-packet restarts; then 99 more back-to-back packets
      do_reset();
      drive_body(16'h0F80 | {12'd0, PID}, 10, 0, 1'b0);
      m_flags |= 6'h10;
      m_err++;
      drive_body(16'h0F80 | {12'd0, PID}, 31, 0, 1'b1);
      for (int i = 1; i < 100; i++) begin
         l   = 9'(1 + (i * 7) % 60);
         hdr = {l, 3'(i % 8), PID};
         wait_ready(n);
         drive_body(hdr, int'(l), 0, 1'b1);
      end
      @(negedge clk);
      chk("t6_pkt_cnt", 32'(pkt_cnt),   32'd100);
      chk("t6_err_cnt", 32'(err_cnt),   32'd1);
      chk("t6_flags",   32'(err_flags), 32'h10);

      // zero-length header with a bare eop
      wait_ready(n);
      drive_body({9'd0, 3'd3, PID}, 0, 0, 1'b1);
      @(negedge clk);
      chk("t7_flags",   32'(err_flags), 32'h11);
      chk("t7_err_cnt", 32'(err_cnt),   32'd2);

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
